// File: rtl/uart_receiver_pkg.sv
// accellant_uart_pkg: shared UART framing constants, receiver states and baud divider helper
package accellant_uart_pkg;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} uart_rx_state_e;
    function automatic int baud_div(input longint clk_hz, input longint baud, input longint os);
        longint d;
        d = (clk_hz + (baud * os) / 2) / (baud * os);
        return d < 1 ? 1 : int'(d);
    endfunction
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: byte stream handshake and line status pulses from the receiver
interface uart_receiver_if;
    import accellant_uart_pkg::*;
    logic [UART_DATA_BITS-1:0] rx_data_o;
    logic rx_valid_o;
    logic rx_ready_i;
    logic frame_err_o;
    logic overrun_o;
    modport master (output rx_data_o, rx_valid_o, frame_err_o, overrun_o, input rx_ready_i);
    modport slave (input rx_data_o, rx_valid_o, frame_err_o, overrun_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through sync FIFO; head output holds the last popped word when empty
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign do_push = push && (!full || do_pop);
    assign rdata = empty ? last_q : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling 8N1 receiver feeding a small FWFT byte FIFO with valid/ready output
module uart_receiver
    import accellant_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    uart_receiver_if.master   bus
);
    localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_START = 3'(START);
    localparam logic [2:0] S_DATA  = 3'(DATA);
    localparam logic [2:0] S_STOP  = 3'(STOP);
    localparam logic [2:0] S_BREAK = 3'(BREAK_WAIT);
    logic sync1, sync2, tick, centre_half, centre_full, start_det;
    logic push, pop, full, empty, ferr_q, ovr_q;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] bcnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [2:0] state;
    assign tick = div_cnt == '0;
    assign start_det = state == S_IDLE && !sync2;
    assign centre_half = tick && tcnt == TW'(OVERSAMPLE / 2 - 1);
    assign centre_full = tick && tcnt == TW'(OVERSAMPLE - 1);
    assign push = state == S_STOP && centre_full && sync2;
    assign pop = !empty && bus.rx_ready_i;
    assign bus.rx_valid_o = !empty;
    assign bus.frame_err_o = ferr_q;
    assign bus.overrun_o = ovr_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            div_cnt <= '0;
            tcnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            state   <= S_IDLE;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1   <= rx_i;
            sync2   <= sync1;
            ferr_q  <= state == S_STOP && centre_full && !sync2;
            ovr_q   <= push && full && !pop;
            div_cnt <= (start_det || tick) ? DW'(DIV - 1) : div_cnt - 1'b1;
            // tick count restarts at every sample point so the next one lands a full bit later
            if (state == S_IDLE)
                tcnt <= '0;
            else if (tick)
                tcnt <= (centre_full || (state == S_START && centre_half)) ? '0 : tcnt + 1'b1;
            case (state)
                S_IDLE: begin
                    bcnt <= '0;
                    if (!sync2) state <= S_START;
                end
                S_START: if (centre_half) state <= sync2 ? S_IDLE : S_DATA;
                S_DATA: if (centre_full) begin
                    shreg <= {sync2, shreg[UART_DATA_BITS-1:1]};
                    bcnt  <= bcnt + 1'b1;
                    if (bcnt == BW'(UART_DATA_BITS - 1)) state <= S_STOP;
                end
                S_STOP: if (centre_full) state <= sync2 ? S_IDLE : S_BREAK;
                S_BREAK: if (sync2) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
    uart_rx_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (shreg),
        .rdata (bus.rx_data_o),
        .full  (full),
        .empty (empty)
    );
endmodule
